// File: rtl/seq_impl_checker_pkg.sv
// Shared types and helpers for the seq_impl_checker slice.
// Pipeline depth, result encoding and delay limits.
package seq_chk_pkg;

  localparam int DELAY_MAX = 32;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_PASS,
    RES_FAIL_A,
    RES_FAIL_B
  } result_e;

  // Index 0 holds the pre-a flag only in non-overlapped mode.
  function automatic int pipe_depth(
    input int delay,
    input int overlap
  );
    return delay + 1 - overlap;
  endfunction

endpackage

// File: rtl/seq_impl_checker_if.sv
// Observed bus for seq_impl_checker: antecedent and consequent terms.
// Master drives the bus, slave (the checker) samples it.
interface seq_impl_checker_if;

  logic valid_i;
  logic a_i;
  logic b_i;

  modport master (
    output valid_i,
    output a_i,
    output b_i
  );

  modport slave (
    input valid_i,
    input a_i,
    input b_i
  );

endinterface

// File: rtl/seq_impl_checker_sat_counter.sv
// Saturating counter with synchronous clear and a 0/1/2 increment.
// Clear wins over any increment in the same cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic [1:0]   inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W+1:0] sum;

  always_comb begin
    sum   = {2'b00, cnt_q} + {{W{1'b0}}, inc_i};
    cnt_d = (sum[W+1:W] != 2'b00) ? '1 : sum[W-1:0];
    if (clear_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_impl_checker.sv
// Hardware monitor for "valid |-> a ##DELAY b" with pass/fail stats.
// Define SEQ_CHK_TIMESTAMP_EN to build the first-fail stamp pipeline.
module seq_impl_checker
  import seq_chk_pkg::*;
#(
  parameter int DELAY   = 3,
  parameter int OVERLAP = 0,
  parameter int CNT_W   = 16,
  parameter int CYC_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic               clear_i,
  seq_impl_checker_if.slave  mon,
  output logic               pass_o,
  output logic               fail_a_o,
  output logic               fail_b_o,
  output logic [CNT_W-1:0]   pass_cnt_o,
  output logic [CNT_W-1:0]   fail_cnt_o,
  output logic               first_fail_vld_o,
  output logic [CYC_W-1:0]   first_fail_start_o
);

  localparam int DEPTH = pipe_depth(DELAY, OVERLAP);
  localparam int LAST  = DEPTH - 1;
  localparam int A0    = 1 - OVERLAP;

  if ((DELAY < 1) || (DELAY > DELAY_MAX) ||
      (OVERLAP < 0) || (OVERLAP > 1)) begin : g_bad_cfg
    $error("seq_impl_checker: DELAY must be 1..32, OVERLAP 0..1");
  end

  logic [LAST:0] flag_q, flag_d;
  logic          start;
  logic          a_chk;
  logic          b_chk;
  logic          pass_d, fail_a_d, fail_b_d;
  logic          pass_q, fail_a_q, fail_b_q;
  logic          ff_vld_q, ff_vld_d;
  result_e       b_res;

  assign start = mon.valid_i & enable_i;
  assign b_chk = flag_q[LAST];

  if (OVERLAP == 0) begin : g_a_late
    assign a_chk = flag_q[0];
  end else begin : g_a_same
    assign a_chk = start;
  end

  // Surviving attempts shift toward the b-check stage one per cycle.
  always_comb begin
    flag_d     = flag_q << 1;
    flag_d[0]  = start;
    flag_d[A0] = a_chk & mon.a_i;
  end

  always_comb begin
    b_res = RES_NONE;
    unique case (1'b1)
      (b_chk &  mon.b_i): b_res = RES_PASS;
      (b_chk & ~mon.b_i): b_res = RES_FAIL_B;
      default: ;
    endcase
  end

  assign pass_d   = (b_res == RES_PASS);
  assign fail_b_d = (b_res == RES_FAIL_B);
  assign fail_a_d = a_chk & ~mon.a_i;
  assign ff_vld_d = clear_i ? 1'b0
                  : (ff_vld_q | fail_a_d | fail_b_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q   <= '0;
      pass_q   <= 1'b0;
      fail_a_q <= 1'b0;
      fail_b_q <= 1'b0;
      ff_vld_q <= 1'b0;
    end else begin
      flag_q   <= flag_d;
      pass_q   <= pass_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .inc_i   ({1'b0, pass_d}),
    .cnt_o   (pass_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .inc_i   ({fail_a_d & fail_b_d, fail_a_d ^ fail_b_d}),
    .cnt_o   (fail_cnt_o)
  );

`ifdef SEQ_CHK_TIMESTAMP_EN
  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] stamp_q [DEPTH];
  logic [CYC_W-1:0] st_a;
  logic [CYC_W-1:0] ff_start_q, ff_start_d;

  if (OVERLAP == 0) begin : g_st_late
    assign st_a = stamp_q[0];
  end else begin : g_st_same
    assign st_a = cyc_q;
  end

  // The b-fail is the older attempt, so it wins a tie.
  always_comb begin
    ff_start_d = ff_start_q;
    if (clear_i)
      ff_start_d = '0;
    else if (!ff_vld_q && (fail_a_d || fail_b_d))
      ff_start_d = fail_b_d ? stamp_q[LAST] : st_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q      <= '0;
      stamp_q    <= '{default: '0};
      ff_start_q <= '0;
    end else begin
      cyc_q      <= cyc_q + 1'b1;
      stamp_q[0] <= cyc_q;
      for (int i = 1; i < DEPTH; i++)
        stamp_q[i] <= stamp_q[i-1];
      ff_start_q <= ff_start_d;
    end
  end

  assign first_fail_start_o = ff_start_q;
`else
  assign first_fail_start_o = '0;
`endif

  assign pass_o           = pass_q;
  assign fail_a_o         = fail_a_q;
  assign fail_b_o         = fail_b_q;
  assign first_fail_vld_o = ff_vld_q;

endmodule

// File: tb/tb_seq_impl_checker.sv
// Scoreboard bench: two checker configs share one bus, each
// compared against an attempt-list reference model.
module tb_seq_impl_checker;
  import seq_chk_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  seq_impl_checker_if bus ();

  logic        pass0, fa0, fb0, fv0;
  logic [15:0] pc0, fc0, fs0;
  logic        pass1, fa1, fb1, fv1;
  logic [1:0]  pc1, fc1;
  logic [15:0] fs1;

  seq_impl_checker #(
    .DELAY(3), .OVERLAP(0), .CNT_W(16), .CYC_W(16)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .clear_i(clr),
    .mon(bus.slave),
    .pass_o(pass0), .fail_a_o(fa0), .fail_b_o(fb0),
    .pass_cnt_o(pc0), .fail_cnt_o(fc0),
    .first_fail_vld_o(fv0), .first_fail_start_o(fs0)
  );

  seq_impl_checker #(
    .DELAY(2), .OVERLAP(1), .CNT_W(2), .CYC_W(16)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .clear_i(clr),
    .mon(bus.slave),
    .pass_o(pass1), .fail_a_o(fa1), .fail_b_o(fb1),
    .pass_cnt_o(pc1), .fail_cnt_o(fc1),
    .first_fail_vld_o(fv1), .first_fail_start_o(fs1)
  );

  logic p_a[2], fa_a[2], fb_a[2], fv_a[2];
  int   pc_a[2], fc_a[2], fs_a[2];

  assign p_a[0]  = pass0;
  assign p_a[1]  = pass1;
  assign fa_a[0] = fa0;
  assign fa_a[1] = fa1;
  assign fb_a[0] = fb0;
  assign fb_a[1] = fb1;
  assign fv_a[0] = fv0;
  assign fv_a[1] = fv1;
  assign pc_a[0] = int'(pc0);
  assign pc_a[1] = int'(pc1);
  assign fc_a[0] = int'(fc0);
  assign fc_a[1] = int'(fc1);
  assign fs_a[0] = int'(fs0);
  assign fs_a[1] = int'(fs1);

  int DL[2] = '{3, 2};
  int OV[2] = '{0, 1};
  int CW[2] = '{16, 2};

  typedef struct {
    int start;
    int ca;
    int cb;
    bit aok;
  } att_t;

  typedef struct {
    int cyc;
    bit p;
    bit fa;
    bit fb;
    int pc;
    int fc;
    bit fv;
    int fs;
  } exp_t;

  att_t att_q[2][$];
  exp_t exp_q[2][$];
  int   pc_m[2], fc_m[2], fs_m[2];
  bit   fv_m[2];

  int checks = 0;
  int failures = 0;
  int next_edge = 0;
  int cur_edge = -1;

  function automatic int fs_exp(input int s);
`ifdef SEQ_CHK_TIMESTAMP_EN
    return s;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: every attempt is a record with its a- and b-check edges.
  task automatic step(input int i, input int n,
                      input bit v, input bit e, input bit a,
                      input bit b, input bit c);
    att_t t;
    att_t keep[$];
    exp_t x;
    bit   np = 0;
    bit   nfa = 0;
    bit   nfb = 0;
    int   sa = 0;
    int   sb = 0;
    int   mx;
    mx = (1 << CW[i]) - 1;
    if (v && e) begin
      t.start = n;
      t.ca    = n + 1 - OV[i];
      t.cb    = t.ca + DL[i];
      t.aok   = 0;
      att_q[i].push_back(t);
    end
    for (int j = 0; j < att_q[i].size(); j++) begin
      t = att_q[i][j];
      if (!t.aok && t.ca == n) begin
        if (a) t.aok = 1;
        else begin
          nfa = 1;
          sa  = t.start;
          continue;
        end
      end
      if (t.aok && t.cb == n) begin
        if (b) np = 1;
        else begin
          nfb = 1;
          sb  = t.start;
        end
        continue;
      end
      keep.push_back(t);
    end
    att_q[i] = keep;
    if (c) begin
      pc_m[i] = 0;
      fc_m[i] = 0;
      fv_m[i] = 0;
      fs_m[i] = 0;
    end else begin
      pc_m[i] = (pc_m[i] + np > mx) ? mx : pc_m[i] + np;
      fc_m[i] = (fc_m[i] + nfa + nfb > mx) ? mx
              : fc_m[i] + nfa + nfb;
      if (!fv_m[i] && (nfa || nfb)) begin
        fv_m[i] = 1;
        fs_m[i] = nfb ? sb : sa;
      end
    end
    if (np || nfa || nfb) begin
      x.cyc = n;
      x.p   = np;
      x.fa  = nfa;
      x.fb  = nfb;
      x.pc  = pc_m[i];
      x.fc  = fc_m[i];
      x.fv  = fv_m[i];
      x.fs  = fs_m[i];
      exp_q[i].push_back(x);
    end
  endtask

  // Drive inputs for the next edge, then account for that edge.
  task automatic drive_edge(input bit v, input bit e, input bit a,
                            input bit b, input bit c);
    int n;
    bus.valid_i = v;
    en          = e;
    bus.a_i     = a;
    bus.b_i     = b;
    clr         = c;
    @(posedge clk);
    #2;
    n = next_edge;
    next_edge++;
    cur_edge = n;
    for (int i = 0; i < 2; i++) step(i, n, v, e, a, b, c);
  endtask

  task automatic run_vec(input int len, input logic [15:0] v,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c);
    for (int k = 0; k < len; k++)
      drive_edge(v[k], 1'b1, a[k], b[k], c[k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.a_i     = 1'b0;
    bus.b_i     = 1'b0;
    en          = 1'b0;
    clr         = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_rst_pulses", i),
          int'({p_a[i], fa_a[i], fb_a[i]}), 0);
      chk($sformatf("u%0d_rst_pass_cnt", i), pc_a[i], 0);
      chk($sformatf("u%0d_rst_fail_cnt", i), fc_a[i], 0);
      chk($sformatf("u%0d_rst_ff", i),
          int'(fv_a[i]) + fs_a[i], 0);
      chk($sformatf("u%0d_pending_exp", i), exp_q[i].size(), 0);
      exp_q[i].delete();
      att_q[i].delete();
      pc_m[i] = 0;
      fc_m[i] = 0;
      fs_m[i] = 0;
      fv_m[i] = 0;
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n     = 1'b1;
    next_edge = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (p_a[i] || fa_a[i] || fb_a[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL u%0d_unexpected_pulse: edge %0d p=%0b fa=%0b fb=%0b required none",
                     i, cur_edge, p_a[i], fa_a[i], fb_a[i]);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("u%0d_edge", i), cur_edge, e.cyc);
            chk($sformatf("u%0d_pulses@%0d", i, e.cyc),
                int'({p_a[i], fa_a[i], fb_a[i]}),
                int'({e.p, e.fa, e.fb}));
            chk($sformatf("u%0d_pass_cnt@%0d", i, e.cyc), pc_a[i], e.pc);
            chk($sformatf("u%0d_fail_cnt@%0d", i, e.cyc), fc_a[i], e.fc);
            chk($sformatf("u%0d_ff_vld@%0d", i, e.cyc),
                int'(fv_a[i]), int'(e.fv));
            chk($sformatf("u%0d_ff_start@%0d", i, e.cyc),
                fs_a[i], fs_exp(e.fs));
          end
        end
      end
    end
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.a_i     = 1'b0;
    bus.b_i     = 1'b0;

    do_reset();
    run_vec(8, 16'h0001, 16'h0002, 16'h0010, 16'h0000);
    chk("t1_pass_cnt", pc_a[0], 1);
    chk("t1_fail_cnt", fc_a[0], 0);

    do_reset();
    run_vec(6, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
    chk("t2_ff_vld", int'(fv_a[0]), 1);
    chk("t2_ff_start", fs_a[0], 0);

    do_reset();
    run_vec(10, 16'h000F, 16'h001E, 16'h0050, 16'h0000);
    chk("t3_pass_cnt", pc_a[0], 2);
    chk("t3_fail_cnt", fc_a[0], 2);
    chk("t3_ff_start", fs_a[0], fs_exp(1));

    do_reset();
    run_vec(10, 16'h0009, 16'h0002, 16'h0000, 16'h0000);
    chk("t4_fail_cnt", fc_a[0], 2);
    chk("t4_ff_start", fs_a[0], 0);

    do_reset();
    run_vec(3, 16'h0001, 16'h0002, 16'h0000, 16'h0000);
    do_reset();
    run_vec(8, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("t5_pass_cnt", pc_a[0], 0);
    chk("t5_fail_cnt", fc_a[0], 0);

    do_reset();
    run_vec(6, 16'h001F, 16'hFFFF, 16'hFFFF, 16'h0000);
    chk("t6_sat_pass_cnt", pc_a[1], 3);
    run_vec(6, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001);
    chk("t6_clear_pass_cnt", pc_a[1], 0);

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(999) < 3) begin
        do_reset();
      end else begin
        drive_edge($urandom_range(99) < 60,
                   $urandom_range(99) < 90,
                   $urandom_range(99) < 80,
                   $urandom_range(99) < 70,
                   $urandom_range(99) < 2);
      end
    end
    run_vec(8, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("u%0d_drained", i), exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
